pc_sequencer: RTL

Parametrised program-counter sequencer that drives the `pc` input of the single-cycle core (mipsdemo and its wider successors). It replaces the free-running external PC increment with a controlled sequencer. The sequencer supports run, single-step, halt, stall, branch load, end-of-program detection and a retired-instruction count. It sits between the debug/control logic and the core's instruction-fetch PC port.

---
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of control, branch and status signals between the debug/control
// logic (master) and the program-counter sequencer (slave).
// Optional feature macro: BREAKPOINT_EN adds i_bpAddr / o_bpHit.
interface pc_sequencer_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
);
   logic             i_start;
   logic             i_step;
   logic             i_haltReq;
   logic             i_stall;
   logic             i_brValid;
   logic [PC_W-1:0]  i_brTarget;
   logic [PC_W-1:0]  o_pc;
   logic             o_pcValid;
   logic [1:0]       o_state;
   logic             o_done;
   logic             o_err;
   logic [CNT_W-1:0] o_retired;
`ifdef BREAKPOINT_EN
   logic [PC_W-1:0]  i_bpAddr;
   logic             o_bpHit;
`endif

   modport master (
`ifdef BREAKPOINT_EN
      output i_bpAddr,
      input  o_bpHit,
`endif
      output i_start, i_step, i_haltReq, i_stall, i_brValid, i_brTarget,
      input  o_pc, o_pcValid, o_state, o_done, o_err, o_retired
   );

   modport slave (
`ifdef BREAKPOINT_EN
      input  i_bpAddr,
      output o_bpHit,
`endif
      input  i_start, i_step, i_haltReq, i_stall, i_brValid, i_brTarget,
      output o_pc, o_pcValid, o_state, o_done, o_err, o_retired
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding the single-cycle core's fetch PC.
// Supports run, single-step, halt, stall, branch load, end-of-program
// detection (sticky done), out-of-range branch detection (sticky err) and a
// saturating retired-instruction counter. All outputs are registered.
// Optional feature macro: BREAKPOINT_EN (halt in RUN when pc hits i_bpAddr).
module pc_sequencer #(
   parameter int PC_W     = 8,
   parameter int PROG_LEN = 21,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   // One extra bit so PROG_LEN == 2**PC_W still compares correctly.
   localparam logic [PC_W:0]   PROG_LEN_W = PROG_LEN[PC_W:0];
   localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LEN - 1);
   localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic             r_pcValid;
   logic             r_done;
   logic             r_err;
   logic [CNT_W-1:0] r_retired;
`ifdef BREAKPOINT_EN
   logic             r_bpHit;
   logic             r_bpSkip;
`endif

   logic [CNT_W-1:0] w_retiredInc;
   logic             w_brOut;
   logic             w_last;
   logic [PC_W-1:0]  w_nextPc;

   // Retire count saturates instead of wrapping back to zero.
   assign w_retiredInc = (r_retired == '1) ? r_retired : r_retired + 1'b1;
   // A taken branch pointing past the program is an error and ends execution.
   assign w_brOut      = bus.i_brValid && ({1'b0, bus.i_brTarget} >= PROG_LEN_W);
   // The last-instruction check precedes the increment, so pc+1 never wraps.
   assign w_last       = !bus.i_brValid && (r_pc == LAST_PC);
   assign w_nextPc     = bus.i_brValid ? bus.i_brTarget : r_pc + 1'b1;

   // Sequencer state machine: all status outputs are updated together here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pc      <= RESET_PC_W;
         r_pcValid <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_retired <= '0;
`ifdef BREAKPOINT_EN
         r_bpHit   <= 1'b0;
         r_bpSkip  <= 1'b0;
`endif
      end else begin
`ifdef BREAKPOINT_EN
         r_bpHit <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_state   <= ST_RUN;
                  r_pcValid <= 1'b1;
`ifdef BREAKPOINT_EN
                  r_bpSkip  <= 1'b1;
`endif
               end else if (bus.i_step) begin
                  r_state   <= ST_STEP;
                  r_pcValid <= 1'b1;
               end
            end
            ST_RUN: begin
`ifdef BREAKPOINT_EN
               r_bpSkip <= 1'b0;
`endif
               if (bus.i_haltReq) begin
                  r_state   <= ST_HALT;
                  r_pcValid <= 1'b0;
`ifdef BREAKPOINT_EN
               end else if ((r_pc == bus.i_bpAddr) && !r_bpSkip) begin
                  r_state   <= ST_HALT;
                  r_pcValid <= 1'b0;
                  r_bpHit   <= 1'b1;
`endif
               end else if (!bus.i_stall) begin
                  r_retired <= w_retiredInc;
                  if (w_brOut) begin
                     r_err     <= 1'b1;
                     r_done    <= 1'b1;
                     r_state   <= ST_HALT;
                     r_pcValid <= 1'b0;
                  end else if (w_last) begin
                     r_done    <= 1'b1;
                     r_state   <= ST_HALT;
                     r_pcValid <= 1'b0;
                  end else begin
                     r_pc <= w_nextPc;
                  end
               end
            end
            ST_STEP: begin
               if (!bus.i_stall) begin
                  r_state   <= ST_HALT;
                  r_pcValid <= 1'b0;
                  if (!bus.i_haltReq) begin
                     r_retired <= w_retiredInc;
                     if (w_brOut) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                     end else if (w_last) begin
                        r_done <= 1'b1;
                     end else begin
                        r_pc <= w_nextPc;
                     end
                  end
               end
            end
            ST_HALT: begin
               if (bus.i_start) begin
                  r_state   <= ST_RUN;
                  r_pcValid <= 1'b1;
`ifdef BREAKPOINT_EN
                  r_bpSkip  <= 1'b1;
`endif
                  if (r_done) begin
                     r_pc      <= RESET_PC_W;
                     r_retired <= '0;
                     r_done    <= 1'b0;
                     r_err     <= 1'b0;
                  end
               end else if (bus.i_step && !r_done) begin
                  r_state   <= ST_STEP;
                  r_pcValid <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.o_pc      = r_pc;
   assign bus.o_pcValid = r_pcValid;
   assign bus.o_state   = r_state;
   assign bus.o_done    = r_done;
   assign bus.o_err     = r_err;
   assign bus.o_retired = r_retired;
`ifdef BREAKPOINT_EN
   assign bus.o_bpHit   = r_bpHit;
`endif

endmodule
